mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
Multicycle sequencing controller for the MIPS core. It steps each instruction through fetch, decode, execute, memory and writeback, and waits on a memory ready handshake. It drives the PC update block's enable, branch-select and jump controls, so the PC changes exactly once per retired instruction. It also flags illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
WAIT_LIMIT, 255, max cycles spent waiting for mem_ready in any memory state before a bus error (1..65535)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clock clk
opcode  input  6  instr[31:26] from the instruction register
funct  input  6  instr[5:0] from the instruction register
zero  input  1  ALU zero flag, valid in BRANCH state
mem_ready  input  1  memory completes the current read/write this cycle
pc_en  output  1  PC update enable, one cycle per instruction
pcsel  output  1  branch taken (beq & zero), qualified by pc_en
jump  output  1  take {pc[31:26], target}, qualified by pc_en
ir_write  output  1  latch the fetched word into the IR
mem_read  output  1  memory read request (instruction or data)
mem_write  output  1  memory write request
reg_write  output  1  register file write
mem_to_reg  output  1  writeback source is memory data
reg_dst  output  1  1 = rd (R-type), 0 = rt
alu_src  output  1  1 = sign-extended immediate
alu_ctl  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt
illegal  output  1  sticky, unsupported opcode/funct trapped
bus_err  output  1  sticky, mem_ready timeout
state_dbg  output  4  current state encoding
retired  output  CNT_W  retired-instruction count

Behaviour:
- States: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_R=7, WB_MEM=8, BRANCH=9, JUMP=10, TRAP=11.
- Reset: state=FETCH, wait counter=0, retired=0, illegal=0, bus_err=0. While reset is high, every control output is 0. reset mid-instruction abandons the instruction with no pc_en.
- FETCH: mem_read=1. On mem_ready, ir_write=1 and go to DECODE. Otherwise stay.
- DECODE: one cycle. Route by opcode:
  - 0x00 -> EXEC_R, only if funct is 0x20/0x22/0x24/0x25/0x2A; any other funct -> TRAP.
  - 0x08 addi -> EXEC_I.
  - 0x23 lw and 0x2B sw -> MEM_ADDR.
  - 0x04 beq -> BRANCH.
  - 0x02 j -> JUMP.
  - Any other opcode -> TRAP.
- EXEC_R: alu_ctl from funct (0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt), reg_dst=1. Next WB_R.
- EXEC_I: alu_src=1, alu_ctl=add. Next WB_R with reg_dst=0.
- WB_R: reg_write=1, pc_en=1, pcsel=0. Next FETCH.
- MEM_ADDR: alu_src=1, alu_ctl=add. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1; on mem_ready -> WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0, pc_en=1. Next FETCH.
- MEM_WR: mem_write=1; on mem_ready, pc_en=1 in that same cycle, then FETCH.
- BRANCH: alu_ctl=sub, pc_en=1, pcsel=zero. Next FETCH.
- JUMP: pc_en=1, jump=1. Next FETCH.
- Outputs are Moore-decoded from state and opcode/funct. The only exceptions are pcsel, which uses zero, and the mem_ready-qualified strobes (ir_write, pc_en in MEM_WR).
- Latency in cycles, zero-wait memory: R/addi 4, lw 5, sw 4, beq 3, j 3.
- Wait counter: increments each cycle in FETCH/MEM_RD/MEM_WR without mem_ready, clears on mem_ready or on any state change. When it reaches WAIT_LIMIT without mem_ready, bus_err=1 and go to TRAP. mem_ready arriving in the limit cycle itself counts as success.
- TRAP: all strobes 0, no pc_en. Only reset exits TRAP. illegal or bus_err stays set until reset.
- retired increments in every cycle with pc_en=1 and wraps modulo 2^CNT_W.
- pc_en is never asserted in two consecutive cycles. pcsel and jump are never both 1.

Decomposition:
- Shared package mips_ctl_pkg holds:
  - state enum constants
  - opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J
  - funct constants
  - ALU_ADD..ALU_SLT codes
- One sub-module, alu_ctl_dec: combinational mapping of funct/state to alu_ctl plus a legal-funct flag. The FSM and counters stay in mc_control_fsm.

Test Plan:
- add (op 0x00, funct 0x20), mem_ready tied 1 -> states 0,1,2,7. reg_write and pc_en=1 in cycle 4, pcsel=0, retired=1.
- lw (0x23), mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then WB_MEM with mem_to_reg=1 and pc_en=1, total 8 cycles.
- beq (0x04): zero=1 -> pc_en=1, pcsel=1 in cycle 3. Repeat with zero=0 -> pcsel=0. j (0x02) -> jump=1, pcsel=0.
- opcode 0x3F, then a separate run with R-type funct 0x01 -> illegal=1, state 11, no pc_en over the next 20 cycles; reset clears everything to FETCH.
- WAIT_LIMIT=4, mem_ready held 0 in FETCH -> bus_err=1 after 4 waiting cycles. A variant with mem_ready on the 4th cycle proceeds normally with bus_err=0.
- reset asserted in MEM_WR during a stall -> next cycle state=FETCH, no mem_write or pc_en, retired unchanged.

Source files
------------

// File: rtl/mips_ctl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states,
// opcode/funct values and ALU operation codes.
package mips_ctl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_WB_R     = 4'd7,
      S_WB_MEM   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   // States that sit on the memory handshake and are subject to the timeout.
   function automatic logic is_wait_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/alu_ctl_dec.sv
// ALU operation decode from FSM state and funct, plus the supported-funct flag
// used by DECODE to trap unknown R-type operations.
module alu_ctl_dec
   import mips_ctl_pkg::*;
(
   input  state_t      state,
   input  logic [5:0]  funct,
   output logic [2:0]  alu_ctl,
   output logic        funct_legal
);

   // Funct values the R-type datapath actually implements.
   always_comb begin
      funct_legal = 1'b0;
      case (funct)
         FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_legal = 1'b1;
         default:                               funct_legal = 1'b0;
      endcase
   end

   // ALU operation per state; only EXEC_R looks at funct.
   always_comb begin
      alu_ctl = ALU_ADD;
      case (state)
         S_EXEC_R: begin
            case (funct)
               FN_ADD:  alu_ctl = ALU_ADD;
               FN_SUB:  alu_ctl = ALU_SUB;
               FN_AND:  alu_ctl = ALU_AND;
               FN_OR:   alu_ctl = ALU_OR;
               FN_SLT:  alu_ctl = ALU_SLT;
               default: alu_ctl = ALU_ADD;
            endcase
         end
         S_EXEC_I, S_MEM_ADDR: alu_ctl = ALU_ADD;
         S_BRANCH:             alu_ctl = ALU_SUB;
         default:              alu_ctl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle sequencing controller: fetch/decode/execute/memory/writeback with
// a mem_ready handshake, timeout trap, illegal-op trap and retired counter.
module mc_control_fsm
   import mips_ctl_pkg::*;
#(
   parameter int unsigned WAIT_LIMIT = 255,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             pcsel,
   output logic             jump,
   output logic             ir_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             reg_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             alu_src,
   output logic [2:0]       alu_ctl,
   output logic             illegal,
   output logic             bus_err,
   output logic [3:0]       state_dbg,
   output logic [CNT_W-1:0] retired
);

   localparam logic [15:0] WAIT_LAST = 16'(WAIT_LIMIT - 1);

   state_t           state_r;
   state_t           state_next_s;
   logic [15:0]      wait_cnt_r;
   logic             illegal_r;
   logic             bus_err_r;
   logic [CNT_W-1:0] retired_r;
   logic [2:0]       alu_ctl_s;
   logic             funct_legal_s;
   logic             waiting_s;
   logic             timeout_s;
   logic             pc_en_s;

   alu_ctl_dec u_alu_ctl_dec (
      .state       (state_r),
      .funct       (funct),
      .alu_ctl     (alu_ctl_s),
      .funct_legal (funct_legal_s)
   );

   // A ready arriving in the limit cycle wins over the timeout.
   assign waiting_s = is_wait_state(state_r) && !mem_ready;
   assign timeout_s = waiting_s && (wait_cnt_r == WAIT_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         S_FETCH: begin
            if (mem_ready)      state_next_s = S_DECODE;
            else if (timeout_s) state_next_s = S_TRAP;
            else                state_next_s = S_FETCH;
         end
         S_DECODE: begin
            case (opcode)
               OP_RTYPE: begin
                  if (funct_legal_s) state_next_s = S_EXEC_R;
                  else               state_next_s = S_TRAP;
               end
               OP_ADDI:      state_next_s = S_EXEC_I;
               OP_LW, OP_SW: state_next_s = S_MEM_ADDR;
               OP_BEQ:       state_next_s = S_BRANCH;
               OP_J:         state_next_s = S_JUMP;
               default:      state_next_s = S_TRAP;
            endcase
         end
         S_EXEC_R, S_EXEC_I: state_next_s = S_WB_R;
         S_MEM_ADDR: begin
            if (opcode == OP_LW) state_next_s = S_MEM_RD;
            else                 state_next_s = S_MEM_WR;
         end
         S_MEM_RD: begin
            if (mem_ready)      state_next_s = S_WB_MEM;
            else if (timeout_s) state_next_s = S_TRAP;
            else                state_next_s = S_MEM_RD;
         end
         S_MEM_WR: begin
            if (mem_ready)      state_next_s = S_FETCH;
            else if (timeout_s) state_next_s = S_TRAP;
            else                state_next_s = S_MEM_WR;
         end
         S_WB_R, S_WB_MEM, S_BRANCH, S_JUMP: state_next_s = S_FETCH;
         S_TRAP:  state_next_s = S_TRAP;
         default: state_next_s = S_TRAP;
      endcase
   end

   // Output decode; everything is forced low while reset is held.
   always_comb begin
      pc_en_s    = 1'b0;
      pcsel      = 1'b0;
      jump       = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      alu_src    = 1'b0;
      alu_ctl    = ALU_ADD;
      if (!reset) begin
         alu_ctl = alu_ctl_s;
         case (state_r)
            S_FETCH: begin
               mem_read = 1'b1;
               ir_write = mem_ready;
            end
            S_EXEC_R:   reg_dst = 1'b1;
            S_EXEC_I:   alu_src = 1'b1;
            S_WB_R: begin
               reg_write = 1'b1;
               pc_en_s   = 1'b1;
               reg_dst   = (opcode == OP_RTYPE);
            end
            S_MEM_ADDR: alu_src = 1'b1;
            S_MEM_RD:   mem_read = 1'b1;
            S_WB_MEM: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               pc_en_s    = 1'b1;
            end
            S_MEM_WR: begin
               mem_write = 1'b1;
               pc_en_s   = mem_ready;
            end
            S_BRANCH: begin
               pc_en_s = 1'b1;
               pcsel   = zero;
            end
            S_JUMP: begin
               pc_en_s = 1'b1;
               jump    = 1'b1;
            end
            default: pc_en_s = 1'b0;
         endcase
      end else begin
         alu_ctl = ALU_ADD;
      end
   end

   // Handshake wait counter; restarts on ready or on any state change.
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt_r <= 16'd0;
      end else if (waiting_s && (state_next_s == state_r)) begin
         wait_cnt_r <= wait_cnt_r + 16'd1;
      end else begin
         wait_cnt_r <= 16'd0;
      end
   end

   // Sticky trap flags, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         illegal_r <= 1'b0;
         bus_err_r <= 1'b0;
      end else begin
         if ((state_r == S_DECODE) && (state_next_s == S_TRAP)) illegal_r <= 1'b1;
         if (timeout_s) bus_err_r <= 1'b1;
      end
   end

   // Retired-instruction counter, wraps naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         retired_r <= '0;
      end else if (pc_en_s) begin
         retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         retired_r <= retired_r;
      end
   end

   assign pc_en     = pc_en_s;
   assign illegal   = illegal_r;
   assign bus_err   = bus_err_r;
   assign state_dbg = state_r;
   assign retired   = retired_r;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle state/strobe checks for each
// instruction class, traps, timeout boundary, reset mid-instruction, wrap.
module tb_mc_control_fsm;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [5:0]       opcode, funct;
   logic             zero, mem_ready;
   logic             pc_en, pcsel, jump, ir_write, mem_read, mem_write;
   logic             reg_write, mem_to_reg, reg_dst, alu_src;
   logic [2:0]       alu_ctl;
   logic             illegal, bus_err;
   logic [3:0]       state_dbg;
   logic [CNT_W-1:0] retired;

   int checks = 0;
   int failures = 0;
   int exp_ret = 0;
   int consec_pc_en = 0;
   int both_sel = 0;
   logic prev_pc_en = 1'b0;

   always #5 clk = ~clk;

   mc_control_fsm #(.WAIT_LIMIT(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_en(pc_en), .pcsel(pcsel), .jump(jump),
      .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
      .alu_src(alu_src), .alu_ctl(alu_ctl), .illegal(illegal), .bus_err(bus_err),
      .state_dbg(state_dbg), .retired(retired)
   );

   // Global invariants sampled mid-cycle.
   always @(negedge clk) begin
      if (!reset) begin
         if (pc_en && prev_pc_en) consec_pc_en = consec_pc_en + 1;
         if (pcsel && jump) both_sel = both_sel + 1;
      end
      prev_pc_en = pc_en;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [12:0] ctl_vec();
      return {pc_en, pcsel, jump, ir_write, mem_read, mem_write, reg_write,
              mem_to_reg, reg_dst, alu_src, alu_ctl};
   endfunction

   task automatic do_reset;
      reset = 1'b1; mem_ready = 1'b1; zero = 1'b1;
      #1;
      check_eq("rst_ctl_zero", 32'(ctl_vec()), 32'd0);
      step; step;
      reset = 1'b0; exp_ret = 0;
      #1;
      check_eq("rst_state", 32'(state_dbg), 32'd0);
      check_eq("rst_flags", 32'({illegal, bus_err}), 32'd0);
      check_eq("rst_retired", 32'(retired), 32'd0);
   endtask

   // Fetch with ready, then decode; leaves the DUT entering the third state.
   task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn);
      opcode = op; funct = fn; mem_ready = 1'b1;
      #1;
      check_eq("fetch_state", 32'(state_dbg), 32'd0);
      check_eq("fetch_rd_irw", 32'({mem_read, ir_write}), 32'd3);
      step; #1;
      check_eq("decode_state", 32'(state_dbg), 32'd1);
      check_eq("decode_no_pc", 32'(pc_en), 32'd0);
      step; #1;
   endtask

   task automatic run_alu(input logic [5:0] op, input logic [5:0] fn, input logic [2:0] exp_alu);
      fetch_decode(op, fn);
      if (op == 6'h00) begin
         check_eq("exec_r_state", 32'(state_dbg), 32'd2);
         check_eq("exec_r_regdst", 32'({reg_dst, alu_src}), 32'd2);
      end else begin
         check_eq("exec_i_state", 32'(state_dbg), 32'd3);
         check_eq("exec_i_alusrc", 32'({reg_dst, alu_src}), 32'd1);
      end
      check_eq("exec_alu_ctl", 32'(alu_ctl), 32'(exp_alu));
      step; #1;
      check_eq("wbr_state", 32'(state_dbg), 32'd7);
      check_eq("wbr_strobes", 32'({reg_write, pc_en, pcsel, jump, mem_to_reg}), 32'b11000);
      check_eq("wbr_regdst", 32'(reg_dst), (op == 6'h00) ? 32'd1 : 32'd0);
      exp_ret++;
      step; #1;
      check_eq("wbr_next_fetch", 32'(state_dbg), 32'd0);
      check_eq("retired", 32'(retired), 32'(exp_ret % 16));
   endtask

   task automatic run_branch(input logic z);
      zero = z;
      fetch_decode(6'h04, 6'h00);
      check_eq("beq_state", 32'(state_dbg), 32'd9);
      check_eq("beq_strobes", 32'({pc_en, pcsel, jump}), 32'({1'b1, z, 1'b0}));
      check_eq("beq_alu_sub", 32'(alu_ctl), 32'd1);
      exp_ret++;
      step; #1;
      check_eq("beq_retired", 32'(retired), 32'(exp_ret % 16));
   endtask

   task automatic run_jump;
      zero = 1'b1;
      fetch_decode(6'h02, 6'h00);
      check_eq("j_state", 32'(state_dbg), 32'd10);
      check_eq("j_strobes", 32'({pc_en, pcsel, jump}), 32'b101);
      exp_ret++;
      step; #1;
      check_eq("j_retired", 32'(retired), 32'(exp_ret % 16));
   endtask

   task automatic run_trap(input logic [5:0] op, input logic [5:0] fn);
      int pc_seen;
      fetch_decode(op, fn);
      check_eq("trap_state", 32'(state_dbg), 32'd11);
      check_eq("trap_illegal", 32'({illegal, bus_err}), 32'd2);
      pc_seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (pc_en || mem_read || mem_write || reg_write) pc_seen++;
         step; #1;
      end
      check_eq("trap_no_strobes", 32'(pc_seen), 32'd0);
      check_eq("trap_stuck", 32'(state_dbg), 32'd11);
      do_reset;
   endtask

   logic [5:0] fn_tab[5]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
   logic [2:0] alu_tab[5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};

   initial begin
      reset = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b1;
      do_reset;

      // add, then every R-type funct and addi
      run_alu(6'h00, 6'h20, 3'b000);
      for (int i = 0; i < 5; i++) run_alu(6'h00, fn_tab[i], alu_tab[i]);
      run_alu(6'h08, 6'h3F, 3'b000);

      // lw with three stall cycles in MEM_RD (ready on the limit cycle)
      fetch_decode(6'h23, 6'h00);
      check_eq("lw_addr_state", 32'(state_dbg), 32'd4);
      check_eq("lw_addr_alusrc", 32'({alu_src, alu_ctl}), 32'b1000);
      step;
      for (int i = 0; i < 4; i++) begin
         mem_ready = (i == 3);
         #1;
         check_eq("lw_memrd_state", 32'(state_dbg), 32'd5);
         check_eq("lw_memrd_strobe", 32'({mem_read, pc_en}), 32'b10);
         step;
      end
      #1;
      check_eq("lw_wbmem_state", 32'(state_dbg), 32'd8);
      check_eq("lw_wbmem_strobes", 32'({reg_write, mem_to_reg, reg_dst, pc_en}), 32'b1101);
      check_eq("lw_no_buserr", 32'(bus_err), 32'd0);
      exp_ret++;
      step; #1;
      check_eq("lw_retired", 32'(retired), 32'(exp_ret % 16));

      // sw, zero-wait
      fetch_decode(6'h2B, 6'h00);
      check_eq("sw_addr_state", 32'(state_dbg), 32'd4);
      step; #1;
      check_eq("sw_memwr_state", 32'(state_dbg), 32'd6);
      check_eq("sw_memwr_strobes", 32'({mem_write, pc_en}), 32'b11);
      exp_ret++;
      step; #1;
      check_eq("sw_next_fetch", 32'(state_dbg), 32'd0);
      check_eq("sw_retired", 32'(retired), 32'(exp_ret % 16));

      run_branch(1'b1);
      run_branch(1'b0);
      run_jump;

      run_trap(6'h3F, 6'h20);
      run_trap(6'h00, 6'h01);

      // Timeout: four waiting cycles in FETCH
      opcode = 6'h02; mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check_eq("to_fetch_wait", 32'({state_dbg, bus_err}), 32'd0);
         step;
      end
      #1;
      check_eq("to_trap_state", 32'(state_dbg), 32'd11);
      check_eq("to_bus_err", 32'({bus_err, illegal}), 32'd2);
      check_eq("to_trap_no_read", 32'(mem_read), 32'd0);
      do_reset;

      // Ready on the fourth cycle is still a success
      opcode = 6'h02;
      for (int i = 0; i < 4; i++) begin
         mem_ready = (i == 3);
         #1;
         check_eq("lim_fetch_state", 32'(state_dbg), 32'd0);
         check_eq("lim_ir_write", 32'(ir_write), (i == 3) ? 32'd1 : 32'd0);
         step;
      end
      #1;
      check_eq("lim_decode", 32'({state_dbg, bus_err}), 32'({4'd1, 1'b0}));
      step; #1;
      check_eq("lim_jump", 32'({state_dbg, jump, pc_en}), 32'({4'd10, 2'b11}));
      step;
      do_reset;

      // Reset during a MEM_WR stall abandons the store
      fetch_decode(6'h2B, 6'h00);
      step;
      mem_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         check_eq("swst_state", 32'(state_dbg), 32'd6);
         check_eq("swst_strobes", 32'({mem_write, pc_en}), 32'b10);
         step;
      end
      reset = 1'b1; mem_ready = 1'b1;
      #1;
      check_eq("swrst_strobes", 32'({mem_write, pc_en}), 32'd0);
      step;
      reset = 1'b0;
      #1;
      check_eq("swrst_state", 32'(state_dbg), 32'd0);
      check_eq("swrst_retired", 32'(retired), 32'd0);
      check_eq("swrst_no_write", 32'({mem_write, pc_en}), 32'd0);

      // Wrap the 4-bit retired counter
      for (int i = 0; i < 17; i++) run_jump;
      check_eq("wrap_retired", 32'(retired), 32'd1);

      check_eq("pc_en_consecutive", 32'(consec_pc_en), 32'd0);
      check_eq("pcsel_and_jump", 32'(both_sel), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
